// File: rtl/sdram_req_bridge.sv
// Registered bridge from the kernel SDRAM strobe bus to the sdram_top request/ack port.
// One transaction at a time; every request is bounded by a timeout counter.
module sdram_req_bridge #(
  parameter int TMO_W = 8
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        sdram_ready,
  input  logic        sdram_stb,
  input  logic        sdram_we,
  input  logic [1:0]  sdram_sel,
  input  logic [21:1] sdram_adr,
  input  logic [15:0] sdram_out,
  output logic [15:0] sdram_dat,
  output logic        sdram_ack,
  output logic        sdr_wr_req,
  output logic        sdr_rd_req,
  input  logic        sdr_wr_ack,
  input  logic        sdr_rd_ack,
  output logic [22:0] sdr_addr,
  output logic [15:0] sdr_wdata,
  input  logic [15:0] sdr_rdata,
  output logic [1:0]  sdr_be,
  output logic        dm_l,
  output logic        dm_h,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [20:0]      adr_q, adr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdat_q, rdat_d;
  logic [1:0]       be_q, be_d;
  logic             dm_l_q, dm_l_d, dm_h_q, dm_h_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  assign cnt_inc = cnt_q + TMO_W'(1);
  // Expires on the (2^TMO_W-1)th request cycle; an ack in that same cycle wins.
  assign tmo_hit = (cnt_inc == {TMO_W{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdat_d  = rdat_q;
    be_d    = be_q;
    dm_l_d  = dm_l_q;
    dm_h_d  = dm_h_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: if (sdram_stb && sdram_ready) begin
        adr_d   = sdram_adr;
        wdata_d = sdram_out;
        be_d    = sdram_sel;
        dm_h_d  = sdram_we ? ~sdram_sel[1] : 1'b0;
        dm_l_d  = sdram_we ? ~sdram_sel[0] : 1'b0;
        cnt_d   = '0;
        state_d = sdram_we ? WR : RD;
      end
      WR: begin
        cnt_d = cnt_inc;
        if (sdr_wr_ack) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      RD: begin
        cnt_d = cnt_inc;
        if (sdr_rd_ack) begin
          rdat_d  = sdr_rdata;
          state_d = DONE;
        end else if (tmo_hit) begin
          rdat_d  = 16'hFFFF;
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (!sdram_stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdat_q  <= '0;
      be_q    <= 2'b00;
      dm_l_q  <= 1'b1;
      dm_h_q  <= 1'b1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdat_q  <= rdat_d;
      be_q    <= be_d;
      dm_l_q  <= dm_l_d;
      dm_h_q  <= dm_h_d;
      tmo_q   <= tmo_d;
    end
  end

  // Requests decode straight from the state flop so reset drops them at once.
  assign sdr_wr_req = (state_q == WR);
  assign sdr_rd_req = (state_q == RD);
  assign sdram_ack  = (state_q == DONE) && sdram_stb;
  assign sdram_dat  = rdat_q;
  assign sdr_addr   = {2'b00, adr_q};
  assign sdr_wdata  = wdata_q;
  assign sdr_be     = be_q;
  assign dm_l       = dm_l_q;
  assign dm_h       = dm_h_q;
  assign tmo_err    = tmo_q;

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed bench for sdram_req_bridge: vector table of whole transactions plus
// hand sequences for ready gating and asynchronous reset mid-read.
module tb_sdram_req_bridge;

  logic        clk_p = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_ready = 1'b0;
  logic        sdram_stb = 1'b0;
  logic        sdram_we = 1'b0;
  logic [1:0]  sdram_sel = 2'b00;
  logic [21:1] sdram_adr = '0;
  logic [15:0] sdram_out = '0;
  logic [15:0] sdram_dat;
  logic        sdram_ack;
  logic        sdr_wr_req, sdr_rd_req;
  logic        sdr_wr_ack = 1'b0, sdr_rd_ack = 1'b0;
  logic [22:0] sdr_addr;
  logic [15:0] sdr_wdata;
  logic [15:0] sdr_rdata = '0;
  logic [1:0]  sdr_be;
  logic        dm_l, dm_h, tmo_err;

  int tests = 0;
  int fails = 0;

  always #5 clk_p = ~clk_p;

  sdram_req_bridge #(.TMO_W(4)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .sdram_ready(sdram_ready),
    .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
    .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
    .sdram_ack(sdram_ack), .sdr_wr_req(sdr_wr_req), .sdr_rd_req(sdr_rd_req),
    .sdr_wr_ack(sdr_wr_ack), .sdr_rd_ack(sdr_rd_ack), .sdr_addr(sdr_addr),
    .sdr_wdata(sdr_wdata), .sdr_rdata(sdr_rdata), .sdr_be(sdr_be),
    .dm_l(dm_l), .dm_h(dm_h), .tmo_err(tmo_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          ack_after;  // request cycle in which the controller acks; 0 = never
    int          drop_at;    // request cycle in which the kernel drops stb; 0 = never
    logic        e_dml, e_dmh;
    logic [15:0] e_dat;
    logic        e_tmo;
    int          e_req;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic we, logic [1:0] sel, logic [20:0] adr, logic [15:0] wd,
                              logic [15:0] rd, int ack_after, int drop_at, logic e_dml,
                              logic e_dmh, logic [15:0] e_dat, logic e_tmo, int e_req);
    vec_t v;
    v.we = we; v.sel = sel; v.adr = adr; v.wd = wd; v.rd = rd;
    v.ack_after = ack_after; v.drop_at = drop_at;
    v.e_dml = e_dml; v.e_dmh = e_dmh; v.e_dat = e_dat; v.e_tmo = e_tmo; v.e_req = e_req;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req"}, {30'd0, sdr_wr_req, sdr_rd_req}, 32'd0);
    chk({tag, " ack"}, {31'd0, sdram_ack}, 32'd0);
    chk({tag, " tmo"}, {31'd0, tmo_err}, 32'd0);
    chk({tag, " dat"}, {16'd0, sdram_dat}, 32'd0);
    chk({tag, " wdata"}, {16'd0, sdr_wdata}, 32'd0);
    chk({tag, " addr"}, {9'd0, sdr_addr}, 32'd0);
    chk({tag, " be_dm"}, {28'd0, sdr_be, dm_h, dm_l}, 32'h3);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int n = 0;
    bit done = 0;
    bit early_ack = 0;
    string t = $sformatf("v%0d", idx);
    sdram_we = v.we; sdram_sel = v.sel; sdram_adr = v.adr;
    sdram_out = v.wd; sdr_rdata = v.rd; sdram_stb = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk_p); #1;
      sdr_wr_ack = 1'b0; sdr_rd_ack = 1'b0;
      if (sdr_wr_req || sdr_rd_req) begin
        n++;
        if (sdram_ack) early_ack = 1;
        if (n == v.drop_at) sdram_stb = 1'b0;
        if (n == v.ack_after) begin
          if (sdr_wr_req) sdr_wr_ack = 1'b1;
          else sdr_rd_ack = 1'b1;
        end
      end else if (n > 0) begin
        done = 1;
      end
    end
    chk({t, " finished"}, {31'd0, done}, 32'd1);
    chk({t, " req_cycles"}, n, v.e_req);
    chk({t, " ack_during_req"}, {31'd0, early_ack}, 32'd0);
    chk({t, " ack"}, {31'd0, sdram_ack}, (v.drop_at == 0) ? 32'd1 : 32'd0);
    chk({t, " dat"}, {16'd0, sdram_dat}, {16'd0, v.e_dat});
    chk({t, " tmo"}, {31'd0, tmo_err}, {31'd0, v.e_tmo});
    chk({t, " dm_h_l"}, {30'd0, dm_h, dm_l}, {30'd0, v.e_dmh, v.e_dml});
    chk({t, " addr"}, {9'd0, sdr_addr}, {11'd0, v.adr});
    chk({t, " be"}, {30'd0, sdr_be}, {30'd0, v.sel});
    chk({t, " wdata"}, {16'd0, sdr_wdata}, {16'd0, v.wd});
    sdram_stb = 1'b0;
    #1 chk({t, " ack_fall"}, {31'd0, sdram_ack}, 32'd0);
    @(posedge clk_p); #1;
    chk({t, " idle"}, {30'd0, sdr_wr_req, sdr_rd_req}, 32'd0);
  endtask

  initial begin
    bit any_req;
    vecs[0] = mk(1, 2'b01, 21'h00100,  16'hA55A, 16'h0000, 3,  0, 0, 1, 16'h0000, 0, 3);
    vecs[1] = mk(0, 2'b11, 21'h1FFFFF, 16'h0000, 16'h1234, 1,  0, 0, 0, 16'h1234, 0, 1);
    vecs[2] = mk(1, 2'b10, 21'h0ABCD,  16'h0F0F, 16'h0000, 2,  0, 1, 0, 16'h1234, 0, 2);
    vecs[3] = mk(1, 2'b00, 21'h15555,  16'hFFFF, 16'h0000, 14, 0, 1, 1, 16'h1234, 0, 14);
    vecs[4] = mk(0, 2'b01, 21'h0AAAA,  16'h1111, 16'hBEEF, 15, 0, 0, 0, 16'hBEEF, 0, 15);
    vecs[5] = mk(0, 2'b10, 21'h00001,  16'h2222, 16'h5678, 0,  0, 0, 0, 16'hFFFF, 1, 15);
    vecs[6] = mk(1, 2'b11, 21'h1F000,  16'hC3C3, 16'h0000, 1,  0, 0, 0, 16'hFFFF, 1, 1);
    vecs[7] = mk(1, 2'b01, 21'h00042,  16'h7777, 16'h0000, 6,  1, 0, 1, 16'hFFFF, 1, 6);
    vecs[8] = mk(0, 2'b11, 21'h00300,  16'h0000, 16'h9ABC, 2,  0, 0, 0, 16'h9ABC, 0, 2);

    repeat (3) @(posedge clk_p);
    #1 chk_reset_vals("reset");
    rst_n = 1'b1; sdram_ready = 1'b1;
    @(posedge clk_p); #1;

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Strobe held while the controller is not ready: no request may start.
    sdram_ready = 1'b0; sdram_we = 1'b0; sdram_sel = 2'b11;
    sdram_adr = 21'h00777; sdr_rdata = 16'h4321; sdram_stb = 1'b1;
    any_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_p); #1;
      if (sdr_wr_req || sdr_rd_req || sdram_ack) any_req = 1;
    end
    chk("notready no_req", {31'd0, any_req}, 32'd0);
    sdram_ready = 1'b1;
    @(posedge clk_p); #1;
    chk("ready rd_req", {31'd0, sdr_rd_req}, 32'd1);
    sdr_rd_ack = 1'b1;
    @(posedge clk_p); #1;
    sdr_rd_ack = 1'b0;
    chk("ready ack", {31'd0, sdram_ack}, 32'd1);
    chk("ready dat", {16'd0, sdram_dat}, 32'h4321);
    sdram_stb = 1'b0;
    @(posedge clk_p); #1;

    // Asynchronous reset in the middle of a read.
    sdram_we = 1'b0; sdram_sel = 2'b01; sdram_adr = 21'h12345; sdram_stb = 1'b1;
    @(posedge clk_p); #1;
    chk("mid rd_req", {31'd0, sdr_rd_req}, 32'd1);
    @(posedge clk_p); #1;
    rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    sdram_stb = 1'b0;
    @(posedge clk_p); #1;
    rst_n = 1'b1;
    @(posedge clk_p); #1;
    run_txn(8, vecs[8]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

endmodule
